// File: rtl/morse_pkg.sv
// Shared Morse definitions: symbol codes, FSM state encoding and the
// unit multiples that set how long each state lasts.
package morse_pkg;

   localparam logic [1:0] SYM_END  = 2'b00;
   localparam logic [1:0] SYM_DOT  = 2'b01;
   localparam logic [1:0] SYM_DASH = 2'b10;
   localparam logic [1:0] SYM_GAP  = 2'b11;

   localparam logic [2:0] DOT_UNITS   = 3'd1;
   localparam logic [2:0] DASH_UNITS  = 3'd3;
   localparam logic [2:0] SPACE_UNITS = 3'd1;
   localparam logic [2:0] GAP_UNITS   = 3'd2;
   localparam logic [2:0] WORD_UNITS  = 3'd7;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_MARK  = 3'd2,
      ST_SPACE = 3'd3,
      ST_GAP   = 3'd4,
      ST_WORD  = 3'd5
   } state_t;

   function automatic logic [2:0] mark_units(input logic [1:0] sym);
      return (sym == SYM_DASH) ? DASH_UNITS : DOT_UNITS;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioning: 2-flop synchroniser, stability debounce and
// a one-cycle Trig pulse on each debounced press (release is ignored).
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic CLK,
   input  logic RST,
   input  logic Pin_In,
   output logic Trig
);

   localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   logic          sync1;
   logic          sync2;
   logic          level;
   logic          level_d;
   logic [DW-1:0] cnt;

   // The counter only runs while the synchronised key disagrees with the
   // debounced level, so any bounce back restarts the stability window.
   always_ff @(posedge CLK) begin
      if (RST) begin
         sync1   <= 1'b0;
         sync2   <= 1'b0;
         level   <= 1'b0;
         level_d <= 1'b0;
         cnt     <= '0;
      end else begin
         sync1   <= Pin_In;
         sync2   <= sync1;
         level_d <= level;
         if (sync2 == level) begin
            cnt <= '0;
         end else if (cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
            level <= sync2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + DW'(1);
         end
      end
   end

   assign Trig = level & ~level_d;

endmodule

// File: rtl/morse_beeper.sv
// Morse message player: a key press latches Pattern and plays it as tone
// bursts; another press aborts, Repeat loops the message with word gaps.
module morse_beeper
   import morse_pkg::*;
#(
   parameter int UNIT_CYCLES     = 50000,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int MAX_SYM         = 16,
   parameter int TONE_HALF       = 12500
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               Pin_In,
   input  logic [2*MAX_SYM-1:0] Pattern,
   input  logic               Repeat,
   output logic               Pin_Out,
   output logic               Beep_En,
   output logic               Busy,
   output logic               Done,
   output logic [2:0]         dbg_state
);

   localparam int UW = $clog2(UNIT_CYCLES);
   localparam int IW = $clog2(MAX_SYM + 1);
   localparam int TW = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;

   state_t               state, next_state;
   logic                 trig;
   logic [2*MAX_SYM-1:0] pat_q;
   logic [IW-1:0]        idx_q;
   logic [UW-1:0]        unit_cnt;
   logic [2:0]           unit_num;
   logic [TW-1:0]        tone_cnt;
   logic                 tone_q;
   logic                 done_q;
   logic [1:0]           cur_sym;
   logic [2:0]           seg_units;
   logic                 unit_tick, seg_done, msg_end, timed;
   logic                 load, idx_clr, idx_inc, abort, fin;

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .CLK    (CLK),
      .RST    (RST),
      .Pin_In (Pin_In),
      .Trig   (trig)
   );

   always_comb begin
      cur_sym = SYM_END;
      for (int k = 0; k < MAX_SYM; k++) begin
         if (idx_q == IW'(k)) cur_sym = pat_q[2*k +: 2];
      end
   end

   assign msg_end   = (idx_q == IW'(MAX_SYM)) || (cur_sym == SYM_END);
   assign unit_tick = (unit_cnt == UW'(UNIT_CYCLES - 1));
   assign timed     = (state == ST_MARK) || (state == ST_SPACE) ||
                      (state == ST_GAP)  || (state == ST_WORD);

   always_comb begin
      seg_units = SPACE_UNITS;
      case (state)
         ST_MARK: seg_units = mark_units(cur_sym);
         ST_GAP:  seg_units = GAP_UNITS;
         ST_WORD: seg_units = WORD_UNITS;
         default: seg_units = SPACE_UNITS;
      endcase
   end

   assign seg_done = unit_tick && (unit_num == seg_units - 3'd1);

   // Trig outside IDLE is an abort and overrides every other transition.
   always_comb begin
      next_state = state;
      load       = 1'b0;
      idx_clr    = 1'b0;
      idx_inc    = 1'b0;
      abort      = 1'b0;
      fin        = 1'b0;
      if (state == ST_IDLE) begin
         if (trig) begin
            next_state = ST_FETCH;
            load       = 1'b1;
            idx_clr    = 1'b1;
         end
      end else if (trig) begin
         abort      = 1'b1;
         next_state = ST_IDLE;
      end else begin
         case (state)
            ST_FETCH: begin
               if (msg_end) begin
                  if (Repeat) begin
                     next_state = ST_WORD;
                  end else begin
                     next_state = ST_IDLE;
                     fin        = 1'b1;
                  end
               end else if (cur_sym == SYM_GAP) begin
                  next_state = ST_GAP;
               end else begin
                  next_state = ST_MARK;
               end
            end
            ST_MARK: if (seg_done) next_state = ST_SPACE;
            ST_SPACE, ST_GAP: begin
               if (seg_done) begin
                  next_state = ST_FETCH;
                  idx_inc    = 1'b1;
               end
            end
            ST_WORD: begin
               if (seg_done) begin
                  next_state = ST_FETCH;
                  idx_clr    = 1'b1;
               end
            end
            default: next_state = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state  <= ST_IDLE;
         pat_q  <= '0;
         idx_q  <= '0;
         done_q <= 1'b0;
      end else begin
         state  <= next_state;
         done_q <= abort;
         if (load) pat_q <= Pattern;
         if (idx_clr) idx_q <= '0;
         else if (idx_inc) idx_q <= idx_q + IW'(1);
      end
   end

   // Unit counters restart on every state change so durations stay exact.
   always_ff @(posedge CLK) begin
      if (RST) begin
         unit_cnt <= '0;
         unit_num <= '0;
      end else if (!timed || (next_state != state)) begin
         unit_cnt <= '0;
         unit_num <= '0;
      end else if (unit_tick) begin
         unit_cnt <= '0;
         unit_num <= unit_num + 3'd1;
      end else begin
         unit_cnt <= unit_cnt + UW'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         tone_cnt <= '0;
         tone_q   <= 1'b0;
      end else if ((next_state == ST_MARK) && (state != ST_MARK)) begin
         tone_cnt <= '0;
         tone_q   <= 1'b1;
      end else if (state == ST_MARK) begin
         if (tone_cnt == TW'(TONE_HALF - 1)) begin
            tone_cnt <= '0;
            tone_q   <= ~tone_q;
         end else begin
            tone_cnt <= tone_cnt + TW'(1);
         end
      end else begin
         tone_cnt <= '0;
         tone_q   <= 1'b0;
      end
   end

   assign Beep_En   = (state == ST_MARK);
   assign Pin_Out   = (state == ST_MARK) & tone_q;
   assign Busy      = (state != ST_IDLE) | trig;
   assign Done      = done_q | fin;
   assign dbg_state = state;

endmodule

// File: tb/tb_morse_beeper.sv
// Scoreboarded bench for morse_beeper: a timeline model predicts marks,
// Done and Busy per run; a negedge monitor pops and compares.
module tb_morse_beeper;

   localparam int U   = 4;
   localparam int DEB = 3;
   localparam int TH  = 1;
   localparam int MS  = 16;
   localparam int LAT = 2 + DEB;

   logic          CLK = 1'b0;
   logic          RST;
   logic          Pin_In;
   logic [2*MS-1:0] Pattern;
   logic          Repeat;
   logic          Pin_Out;
   logic          Beep_En;
   logic          Busy;
   logic          Done;
   logic [2:0]    dbg_state;

   morse_beeper #(
      .UNIT_CYCLES(U), .DEBOUNCE_CYCLES(DEB), .MAX_SYM(MS), .TONE_HALF(TH)
   ) dut (
      .CLK(CLK), .RST(RST), .Pin_In(Pin_In), .Pattern(Pattern), .Repeat(Repeat),
      .Pin_Out(Pin_Out), .Beep_En(Beep_En), .Busy(Busy), .Done(Done),
      .dbg_state(dbg_state)
   );

   always #5 CLK = ~CLK;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // scoreboard queues: marks as {start,len} relative to the Busy rise
   logic [31:0] exp_q[$];
   int          done_q[$];
   int          busy_q[$];
   int          rise_q[$];

   // reference model results
   int m_st[$];
   int m_ln[$];
   int m_end;

   // Timeline of one run, cycle 0 = Busy rise, 1 = first FETCH.
   function automatic void model(input logic [31:0] pat, input bit rep, input int a);
      int t, k, s;
      bit stop;
      m_st.delete();
      m_ln.delete();
      m_end = -1;
      t = 1; k = 0; stop = 0;
      while (!stop && t < 20000) begin
         if (a >= 0 && t > a) begin
            stop = 1;
         end else begin
            s = (k < MS) ? int'(pat[2*k +: 2]) : 0;
            if (s == 0) begin
               if (!rep) begin
                  m_end = t;
                  stop  = 1;
               end else begin
                  t += 1 + 7*U;
                  k = 0;
               end
            end else begin
               t += 1;
               if (s == 1) begin
                  m_st.push_back(t); m_ln.push_back(U); t += 2*U;
               end else if (s == 2) begin
                  m_st.push_back(t); m_ln.push_back(3*U); t += 4*U;
               end else begin
                  t += 2*U;
               end
               k++;
            end
         end
      end
   endfunction

   function automatic void push_expect(input int a, input int rise_abs);
      int len;
      rise_q.push_back(rise_abs);
      if (a < 0) begin
         done_q.push_back(m_end);
         busy_q.push_back(m_end + 1);
      end else begin
         done_q.push_back(a + 1);
         busy_q.push_back(a + 1);
      end
      for (int i = 0; i < m_st.size(); i++) begin
         len = m_ln[i];
         if (a >= 0 && m_st[i] > a) len = 0;
         else if (a >= 0 && a - m_st[i] + 1 < len) len = a - m_st[i] + 1;
         if (len > 0) exp_q.push_back({m_st[i][15:0], len[15:0]});
      end
   endfunction

   // monitor
   int  cyc = 0;
   int  busy_t = 0;
   int  rel;
   int  mk_start, mk_len;
   int  rise_cnt = 0;
   bit  busy_prev = 0, be_prev = 0, pin_ok = 1, mon_en = 0;
   logic [31:0] e;

   always @(negedge CLK) begin
      cyc++;
      if (mon_en) begin
         if (Busy && !busy_prev) begin
            busy_t = cyc;
            rise_cnt++;
            if (rise_q.size() == 0) check("busy_rise_spurious", Busy, 0);
            else check("busy_rise_cycle", cyc, rise_q.pop_front());
         end
         rel = cyc - busy_t;
         if (!Busy && busy_prev) begin
            if (busy_q.size() == 0) check("busy_fall_spurious", Busy, 1);
            else check("busy_fall_rel", rel, busy_q.pop_front());
         end
         if (Beep_En) begin
            if (!be_prev) begin
               mk_start = rel; mk_len = 0; pin_ok = 1;
            end
            if (Pin_Out != (((mk_len / TH) % 2) == 0)) pin_ok = 0;
            mk_len++;
         end else begin
            check("pin_out_silent", Pin_Out, 0);
            if (be_prev) begin
               if (exp_q.size() == 0) begin
                  check("mark_spurious", mk_len, 0);
               end else begin
                  e = exp_q.pop_front();
                  check("mark_start", mk_start, int'(e[31:16]));
                  check("mark_len", mk_len, int'(e[15:0]));
               end
               check("mark_tone", pin_ok, 1);
            end
         end
         if (Done) begin
            if (done_q.size() == 0) check("done_spurious", Done, 0);
            else check("done_rel", rel, done_q.pop_front());
         end
      end
      busy_prev = Busy;
      be_prev   = Beep_En;
   end

   task automatic wait_drain();
      int n = 0;
      while ((exp_q.size() + done_q.size() + busy_q.size() + rise_q.size()) != 0 && n < 3000) begin
         @(negedge CLK);
         n++;
      end
      check("queues_drained", exp_q.size() + done_q.size() + busy_q.size() + rise_q.size(), 0);
      repeat (15) @(negedge CLK);
      #1;
   endtask

   task automatic play(input logic [31:0] pat, input bit rep, input int a,
                       input int hold, input bit scramble);
      int p;
      Pattern = pat;
      Repeat  = rep;
      model(pat, rep, a);
      @(negedge CLK); #1;
      p = cyc;
      push_expect(a, p + LAT);
      Pin_In = 1'b1;
      repeat (hold) @(negedge CLK);
      #1 Pin_In = 1'b0;
      if (scramble) Pattern = $urandom;
      if (a >= 0) begin
         while (cyc < p + a) begin
            @(negedge CLK); #1;
         end
         Pin_In = 1'b1;
         repeat (6) @(negedge CLK);
         #1 Pin_In = 1'b0;
      end
      wait_drain();
   endtask

   logic [31:0] sos;
   logic [31:0] rpat;
   int          sos_sym[11] = '{1, 1, 1, 3, 2, 2, 2, 3, 1, 1, 1};

   initial begin
      int r0, n, len, a;
      bit done_seen;
      RST = 1'b1; Pin_In = 1'b0; Pattern = '0; Repeat = 1'b0;
      repeat (3) @(negedge CLK);
      check("rst_pin_out", Pin_Out, 0);
      check("rst_beep_en", Beep_En, 0);
      check("rst_busy", Busy, 0);
      check("rst_done", Done, 0);
      check("rst_state_idle", dbg_state, 0);
      #1 RST = 1'b0;
      mon_en = 1;
      repeat (5) @(negedge CLK);
      #1;

      // short glitch must not start playback
      r0 = rise_cnt;
      Pin_In = 1'b1;
      repeat (2) @(negedge CLK);
      #1 Pin_In = 1'b0;
      repeat (15) @(negedge CLK);
      #1;
      check("glitch_no_trig", rise_cnt - r0, 0);

      // long hold: exactly one trigger, single dot message
      r0 = rise_cnt;
      play(32'h1, 0, -1, 10, 0);
      check("hold_one_trig", rise_cnt - r0, 1);

      sos = '0;
      for (int k = 0; k < 11; k++) sos[2*k +: 2] = 2'(sos_sym[k]);

      play(sos, 0, -1, 6, 1);
      play(sos, 0, $urandom_range(37, 48), 6, 0);
      play(sos, 1, $urandom_range(160, 200), 6, 1);
      play(32'h0, 0, -1, 6, 0);
      play(32'h5555_5555, 0, -1, 6, 1);

      for (int it = 0; it < 6; it++) begin
         len  = $urandom_range(0, MS);
         rpat = $urandom;
         for (int k = 0; k < MS; k++) begin
            if (k < len) rpat[2*k +: 2] = 2'($urandom_range(1, 3));
            else if (k == len) rpat[2*k +: 2] = 2'b00;
         end
         model(rpat, 0, -1);
         a = -1;
         if (m_end > 30 && $urandom_range(0, 2) == 0) a = $urandom_range(20, m_end - 1);
         play(rpat, 0, a, 6, $urandom_range(0, 1) == 1);
      end

      // reset in the middle of a mark
      mon_en = 0;
      Pattern = 32'h2; Repeat = 1'b0;
      @(negedge CLK); #1 Pin_In = 1'b1;
      repeat (6) @(negedge CLK);
      #1 Pin_In = 1'b0;
      n = 0;
      while (!Beep_En && n < 50) begin
         @(negedge CLK);
         n++;
      end
      check("reset_reached_mark", Beep_En, 1);
      #1 RST = 1'b1;
      @(negedge CLK);
      check("midrst_pin_out", Pin_Out, 0);
      check("midrst_beep_en", Beep_En, 0);
      check("midrst_busy", Busy, 0);
      check("midrst_done", Done, 0);
      #1 RST = 1'b0;
      done_seen = 0;
      repeat (20) begin
         @(negedge CLK);
         done_seen |= Done;
      end
      check("midrst_no_done", done_seen, 0);
      #1 mon_en = 1;

      play(sos, 0, -1, 6, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded its time budget, got no summary, expected one");
      $fatal(1);
   end

endmodule
